// File: rtl/frame_out_pkg.sv
// Shared types and default sizing for the frame output reader.
package frame_out_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam int IMG_W_DEF   = 256;
  localparam int IMG_H_DEF   = 256;
  localparam int FRAME_WORDS = IMG_W_DEF * IMG_H_DEF;
  localparam int IDX_W       = $clog2(FRAME_WORDS);

  // Counter width that stays legal for degenerate sizes of 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding {eof, eol, pix}; absorbs the memory read latency.
module pix_skid_fifo #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/frame_output_reader.sv
// Sweeps the output image region of RAM and streams it as valid/ready pixels.
// Build option: define FRAME_LOOP_EN to restart the sweep after every frame.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads while buffer credit allows
// DRAIN | all reads issued, emptying the buffer
// DONE  | one-cycle done pulse, start may re-launch
module frame_output_reader
  import frame_out_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h34000,
  parameter int               IMG_W     = IMG_W_DEF,
  parameter int               IMG_H     = IMG_H_DEF,
  parameter int               PIX_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdaddress_O,
  input  logic [WIDTH-1:0] q_O,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_eol,
  output logic             pix_eof
);

  localparam int FW = IMG_W * IMG_H;
  localparam int IW = idx_width(FW);
  localparam int XW = idx_width(IMG_W);

  state_t          state;
  logic [IW-1:0]   rd_idx;
  logic [XW-1:0]   col;
  logic            inflight;
  logic            infl_eol;
  logic            infl_eof;
  logic [1:0]      occ;
  logic [1:0]      demand;
  logic [PIX_W+1:0] head;
  logic            pop;
  logic            issue;
  logic            last_idx;
  logic            last_col;
  logic            unused_q;

  assign pop      = pix_valid && pix_ready;
  // Credit: entries held plus the read in flight, net of this cycle's pop.
  assign demand   = occ + {1'b0, inflight} - {1'b0, pop};
  assign issue    = (state == FETCH) && (demand < 2'd2);
  assign last_idx = (rd_idx == IW'(FW - 1));
  assign last_col = (col == XW'(IMG_W - 1));

  assign rdaddress_O = BASE_ADDR + WIDTH'(rd_idx);
  assign unused_q    = ^q_O[WIDTH-1:PIX_W];

  pix_skid_fifo #(.W(PIX_W + 2)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data ({infl_eof, infl_eol, q_O[PIX_W-1:0]}),
    .pop       (pop),
    .head_data (head),
    .occupancy (occ)
  );

  assign pix_valid = (occ != 2'd0);
  assign pix_data  = head[PIX_W-1:0];
  assign pix_eol   = head[PIX_W];
  assign pix_eof   = head[PIX_W+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rd_idx   <= '0;
      col      <= '0;
      inflight <= 1'b0;
      infl_eol <= 1'b0;
      infl_eof <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      infl_eol <= issue && last_col;
      infl_eof <= issue && last_idx;
      done     <= 1'b0;
      if (issue) begin
        rd_idx <= last_idx ? '0 : rd_idx + IW'(1);
        col    <= last_col ? '0 : col + XW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (issue && last_idx) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && pix_eof) begin
            done <= 1'b1;
`ifdef FRAME_LOOP_EN
            state <= FETCH;
`else
            state <= DONE;
            busy  <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_output_reader.sv
// Directed self-checking bench: 4x2 frame, stalls, restart, reset abort, address wrap.
module tb_frame_output_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pix_ready = 1'b1;
  logic        busy, done, pix_valid, pix_eol, pix_eof;
  logic [31:0] rdaddress_O, q_O;
  logic [7:0]  pix_data;

  logic        start_w = 1'b0;
  logic        busy_w, done_w, valid_w, eol_w, eof_w;
  logic [31:0] addr_w, q_w;
  logic [7:0]  data_w;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  frame_output_reader #(
    .WIDTH(32), .BASE_ADDR(32'h34000), .IMG_W(4), .IMG_H(2), .PIX_W(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rdaddress_O(rdaddress_O), .q_O(q_O), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  frame_output_reader #(
    .WIDTH(32), .BASE_ADDR(32'hFFFF_FFFE), .IMG_W(4), .IMG_H(1), .PIX_W(8)
  ) dut_wrap (
    .clock(clock), .reset(reset), .start(start_w), .busy(busy_w), .done(done_w),
    .rdaddress_O(addr_w), .q_O(q_w), .pix_data(data_w),
    .pix_valid(valid_w), .pix_ready(1'b1), .pix_eol(eol_w), .pix_eof(eof_w)
  );

  // Memory models: word k of the region holds k, one cycle read latency.
  always @(posedge clock) begin
    q_O <= rdaddress_O - 32'h34000;
    q_w <= addr_w - 32'hFFFF_FFFE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start presented in cycle 0 (current negedge); ready held high.
  task automatic run_frame(input string name, input int restart_at);
    start = 1'b1;
    pix_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      start = (c == restart_at);
      chk({name, " valid"}, 32'(pix_valid), 32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) begin
        chk({name, " data"}, 32'(pix_data), 32'(c - 3));
        chk({name, " eol"}, 32'(pix_eol), 32'(c == 6 || c == 10));
        chk({name, " eof"}, 32'(pix_eof), 32'(c == 10));
      end
      chk({name, " done"}, 32'(done), 32'(c == 11));
      chk({name, " busy"}, 32'(busy), 32'(c >= 1 && c <= 10));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0]  pat;
    int          exp_pix;
    logic        held;
    logic [7:0]  held_data;
    logic        done_seen;
    logic [31:0] idx;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst valid", 32'(pix_valid), 32'd0);
    chk("rst eol", 32'(pix_eol), 32'd0);
    chk("rst eof", 32'(pix_eof), 32'd0);
    chk("rst data", 32'(pix_data), 32'd0);
    chk("rst addr", rdaddress_O, 32'h34000);
    reset = 1'b0;
    @(negedge clock);

    // Straight frame at full throughput.
    run_frame("full", -1);
    @(negedge clock);

    // Backpressure pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    exp_pix = 0;
    held = 1'b0;
    held_data = '0;
    done_seen = 1'b0;
    start = 1'b1;
    pix_ready = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      start = 1'b0;
      pix_ready = pat[c % 4];
      if (held) begin
        chk("stall valid", 32'(pix_valid), 32'd1);
        chk("stall hold", 32'(pix_data), 32'(held_data));
      end
      if (pix_valid) begin
        idx = rdaddress_O - 32'h34000;
        if (idx >= 32'(pix_data))
          chk("stall lead", 32'(idx - 32'(pix_data) <= 2), 32'd1);
        if (pix_ready) begin
          chk("stall data", 32'(pix_data), 32'(exp_pix));
          chk("stall eol", 32'(pix_eol), 32'(exp_pix % 4 == 3));
          chk("stall eof", 32'(pix_eof), 32'(exp_pix == 7));
          exp_pix++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = pix_data;
        end
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk("stall count", 32'(exp_pix), 32'd8);
    chk("stall done", 32'(done_seen), 32'd1);
    pix_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);

    // Second start mid-frame must be ignored.
    run_frame("restart", 5);
    @(negedge clock);

    // Reset while pixel 4 is presented.
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("abort pre data", 32'(pix_data), 32'd4);
    chk("abort pre valid", 32'(pix_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort valid", 32'(pix_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort addr", rdaddress_O, 32'h34000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("abort quiet valid", 32'(pix_valid), 32'd0);
      chk("abort quiet done", 32'(done), 32'd0);
    end
    run_frame("after abort", -1);
    @(negedge clock);

    // Address wrap past 2^32.
    start_w = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start_w = 1'b0;
      if (c <= 4) chk("wrap addr", addr_w, 32'hFFFF_FFFE + 32'(c - 1));
      chk("wrap valid", 32'(valid_w), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk("wrap data", 32'(data_w), 32'(c - 3));
        chk("wrap eof", 32'(eof_w), 32'(c == 6));
      end
      chk("wrap done", 32'(done_w), 32'(c == 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
